// File: rtl/burst_pkg.sv
// Shared types and widths for the burst interrupter slice.
package burst_pkg;

  localparam int unsigned BURST_CNT_W = 16;
  localparam int unsigned SG_PERIOD_W = 32;
  localparam int unsigned SG_LANES    = 16;

  // Legacy state encodings kept so the enum values match the old build.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ON    = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OFF   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ON    = ST_ON,
    S_DRAIN = ST_DRAIN,
    S_OFF   = ST_OFF
  } burst_state_t;

endpackage

// File: rtl/burst_interrupter_p16_timer.sv
// Shared on/off down-counter; saturates at zero, flags its final counted cycle.
module burst_timer
  import burst_pkg::*;
(
  input  logic                   p_clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   count,
  input  logic [BURST_CNT_W-1:0] load_value,
  output logic                   expired
);

  logic [BURST_CNT_W-1:0] cnt;

  always_ff @(posedge p_clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Count of 1 (or a zero load) marks the last cycle, so N loaded gives N cycles, 0 gives 1.
  assign expired = (cnt[BURST_CNT_W-1:1] == '0);

endmodule

// File: rtl/burst_interrupter_p16.sv
// Burst interrupter: gates a parallel generator word into on/drain/off bursts.
// Optional duty limiting is compiled in with `define BURST_DUTY_LIMIT_EN.
module burst_interrupter_p16
  import burst_pkg::*;
#(
  parameter logic [SG_PERIOD_W-1:0] INITIAL_PERIOD = 32'd1600,
  parameter logic [BURST_CNT_W-1:0] MAX_ON_CYCLES  = 16'd4000,
  parameter logic [BURST_CNT_W-1:0] MIN_OFF_CYCLES = 16'd400
) (
  input  logic                   p_clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [BURST_CNT_W-1:0] on_cycles,
  input  logic [BURST_CNT_W-1:0] off_cycles,
  input  logic [SG_PERIOD_W-1:0] period_req,
  input  logic                   period_req_valid,
  output logic                   period_req_ready,
  output logic [SG_PERIOD_W-1:0] sg_period,
  output logic                   sg_set_period,
  input  logic [SG_LANES-1:0]    sg_p_out,
  output logic [SG_LANES-1:0]    drive_out,
  output logic                   burst_active
);

  logic [BURST_CNT_W-1:0] eff_on;
  logic [BURST_CNT_W-1:0] eff_off;

`ifdef BURST_DUTY_LIMIT_EN
  assign eff_on  = (on_cycles  > MAX_ON_CYCLES)  ? MAX_ON_CYCLES  : on_cycles;
  assign eff_off = (off_cycles < MIN_OFF_CYCLES) ? MIN_OFF_CYCLES : off_cycles;
`else
  logic unused_limits;
  assign unused_limits = ^{MAX_ON_CYCLES, MIN_OFF_CYCLES};
  assign eff_on  = on_cycles;
  assign eff_off = off_cycles;
`endif

  burst_state_t           state;
  burst_state_t           state_next;
  logic                   tmr_load;
  logic [BURST_CNT_W-1:0] tmr_value;
  logic                   tmr_expired;

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_value  = eff_on;
    case (state)
      S_IDLE: begin
        if (enable && (eff_on != '0)) begin
          state_next = S_ON;
          tmr_load   = 1'b1;
        end
      end
      S_ON: begin
        if (tmr_expired || !enable) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (sg_p_out == '0) begin
          state_next = S_OFF;
          tmr_load   = 1'b1;
          tmr_value  = eff_off;
        end
      end
      S_OFF: begin
        if (tmr_expired) begin
          if (enable && (eff_on != '0)) begin
            state_next = S_ON;
            tmr_load   = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  burst_timer u_timer (
    .p_clock    (p_clock),
    .reset      (reset),
    .load       (tmr_load),
    .count      ((state == S_ON) || (state == S_OFF)),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  assign burst_active     = (state == S_ON) || (state == S_DRAIN);
  assign period_req_ready = !reset && ((state == S_IDLE) || (state == S_OFF));

  always_ff @(posedge p_clock) begin
    if (reset) begin
      state     <= S_IDLE;
      drive_out <= '0;
    end else begin
      state     <= state_next;
      drive_out <= burst_active ? sg_p_out : '0;
    end
  end

  always_ff @(posedge p_clock) begin
    if (reset) begin
      sg_period     <= INITIAL_PERIOD;
      sg_set_period <= 1'b0;
    end else if (period_req_valid && period_req_ready) begin
      sg_period     <= period_req;
      sg_set_period <= 1'b1;
    end else begin
      sg_set_period <= 1'b0;
    end
  end

endmodule

// File: tb/tb_burst_interrupter_p16.sv
// Scoreboard bench for burst_interrupter_p16; honours `define BURST_DUTY_LIMIT_EN.
module tb_burst_interrupter_p16;

  typedef struct packed {
    logic        ba;
    logic        rdy;
    logic        set;
    logic [15:0] drv;
    logic [31:0] per;
  } obs_t;

  logic        p_clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] on_cycles;
  logic [15:0] off_cycles;
  logic [31:0] period_req;
  logic        period_req_valid;
  logic        period_req_ready;
  logic [31:0] sg_period;
  logic        sg_set_period;
  logic [15:0] sg_p_out;
  logic [15:0] drive_out;
  logic        burst_active;

  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  obs_t exp_q[$];

  always #5 p_clock = ~p_clock;

  burst_interrupter_p16 #(
    .INITIAL_PERIOD (32'd1600),
    .MAX_ON_CYCLES  (16'd4000),
    .MIN_OFF_CYCLES (16'd400)
  ) dut (
    .p_clock          (p_clock),
    .reset            (reset),
    .enable           (enable),
    .on_cycles        (on_cycles),
    .off_cycles       (off_cycles),
    .period_req       (period_req),
    .period_req_valid (period_req_valid),
    .period_req_ready (period_req_ready),
    .sg_period        (sg_period),
    .sg_set_period    (sg_set_period),
    .sg_p_out         (sg_p_out),
    .drive_out        (drive_out),
    .burst_active     (burst_active)
  );

  function automatic obs_t mk(logic ba, logic rdy, logic set, logic [15:0] drv, logic [31:0] per);
    obs_t r;
    r.ba = ba; r.rdy = rdy; r.set = set; r.drv = drv; r.per = per;
    return r;
  endfunction

  // Periodic burst timeline with enable held: ON on, DRAIN d+1 (zero word last), OFF max(off,1).
  function automatic obs_t prof(int c, int on, int off, int d, logic [31:0] per, logic set);
    int t;
    int p;
    logic ba;
    logic [15:0] drv;
    t   = on + d + 1 + ((off < 1) ? 1 : off);
    p   = (c - 1) % t;
    ba  = (p < on + d + 1);
    drv = ((c >= 2) && (((c - 2) % t) < on + d)) ? 16'hFFFF : 16'h0000;
    return mk(ba, !ba, set, drv, per);
  endfunction

  function automatic logic [15:0] sgw(int k, int on, int off, int d);
    int t;
    if (k == 0) return 16'hFFFF;
    t = on + d + 1 + ((off < 1) ? 1 : off);
    return (((k - 1) % t) == on + d) ? 16'h0000 : 16'hFFFF;
  endfunction

  task automatic check_cycle(input string tag);
    obs_t e;
    obs_t a;
    @(posedge p_clock);
    #1;
    a = {burst_active, period_req_ready, sg_set_period, drive_out, sg_period};
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, a);
    end else begin
      e = exp_q.pop_front();
      assert (a === e) passed++;
      else begin
        fails++;
        $error("FAIL %s: observed ba=%b rdy=%b set=%b drv=%h per=%0d required ba=%b rdy=%b set=%b drv=%h per=%0d",
               tag, a.ba, a.rdy, a.set, a.drv, a.per, e.ba, e.rdy, e.set, e.drv, e.per);
      end
    end
  endtask

  task automatic do_reset(input string tag);
    reset            = 1'b1;
    enable           = 1'b0;
    period_req_valid = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 32'd1600));
    check_cycle(tag);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int eon;
    int eoff;
    int n;
    reset = 1'b1; enable = 1'b0; on_cycles = '0; off_cycles = '0;
    sg_p_out = '0; period_req = '0; period_req_valid = 1'b0;

    do_reset("reset_initial");
    do_reset("reset_hold");

    // Steady bursts: on=10 off=20, two FFFF words in DRAIN before the zero word.
    on_cycles = 16'd10; off_cycles = 16'd20; enable = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      sg_p_out = sgw(c - 1, 10, 20, 2);
      exp_q.push_back(prof(c, 10, 20, 2, 32'd1600, 1'b0));
      check_cycle("burst_steady");
    end

    // Period request held from ON until OFF, then two back-to-back requests.
    do_reset("reset_pre_period");
    on_cycles = 16'd10; off_cycles = 16'd20; enable = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      int k;
      logic [31:0] per_e;
      k = c - 1;
      sg_p_out         = sgw(k, 10, 20, 0);
      period_req_valid = ((k >= 2) && (k <= 12)) || (k == 15) || (k == 16);
      period_req       = (k <= 12) ? 32'd2000 : ((k == 15) ? 32'd3000 : 32'd3500);
      per_e = (c < 13) ? 32'd1600 : (c < 16) ? 32'd2000 : (c == 16) ? 32'd3000 : 32'd3500;
      exp_q.push_back(prof(c, 10, 20, 0, per_e, (c == 13) || (c == 16) || (c == 17)));
      check_cycle("period_req");
    end

    // Reset mid-ON restores IDLE and INITIAL_PERIOD; next burst is a full on-time.
    period_req_valid = 1'b0;
    reset = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 32'd1600));
    check_cycle("reset_mid_on");
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      sg_p_out = sgw(c - 1, 10, 20, 0);
      exp_q.push_back(prof(c, 10, 20, 0, 32'd1600, 1'b0));
      check_cycle("after_reset");
    end

    // enable dropped 3 cycles into ON, generator toggling every 4 cycles.
    do_reset("reset_pre_drop");
    on_cycles = 16'd10; off_cycles = 16'd20;
    for (int c = 1; c <= 40; c++) begin
      int k;
      k = c - 1;
      enable   = (k < 3);
      sg_p_out = (((k + 2) % 8) >= 4) ? 16'hFFFF : 16'h0000;
      exp_q.push_back(mk((c <= 6), !(c <= 6), 1'b0,
                         ((c >= 3) && (c <= 6)) ? 16'hFFFF : 16'h0000, 32'd1600));
      check_cycle("enable_drop");
    end

    // Zero on-time never starts a burst.
    do_reset("reset_pre_zero");
    on_cycles = 16'd0; off_cycles = 16'd20; enable = 1'b1; sg_p_out = 16'hFFFF;
    for (int c = 1; c <= 100; c++) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 32'd1600));
      check_cycle("on_zero");
    end

    // Duty limiting clamp (or pass-through when not compiled in).
`ifdef BURST_DUTY_LIMIT_EN
    eon = 4000; eoff = 400;
`else
    eon = 9000; eoff = 10;
`endif
    do_reset("reset_pre_limit");
    on_cycles = 16'd9000; off_cycles = 16'd10; enable = 1'b1;
    n = eon + 1 + eoff + 3;
    for (int c = 1; c <= n; c++) begin
      sg_p_out = sgw(c - 1, eon, eoff, 0);
      exp_q.push_back(prof(c, eon, eoff, 0, 32'd1600, 1'b0));
      check_cycle("duty_limit");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
